uart_loader: RTL

- Parametrised successor to the current UART reprogram path.
- Receives a raw byte stream on a UART line and assembles bytes little-endian into DATA_W-bit words.
- Emits each word with an auto-incrementing word address over a valid/ready write handshake toward the memory block.
- Keeps a running XOR checksum and error status for LED display; sits beside memory in the top level, driven by the 50 MHz system clock.

---
 rtl/fgba_loader_pkg.sv | 22 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 rtl/uart_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fgba_loader_pkg.sv
// Shared definitions for the UART loader: RX state encoding, bit-timing helper
// and byte width. LOADER_PARITY_EN adds the PARITY state (8E1 framing).
package fgba_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef LOADER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_e;

    // Clock cycles per UART bit, truncated.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchroniser, bit timer and framing FSM.
// Emits a one-cycle byte_valid with the byte, or a one-cycle err pulse on a
// bad stop bit. With LOADER_PARITY_EN the frame is 8E1 and a parity mismatch
// also produces err instead of byte_valid.
module uart_rx
    import fgba_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [2:0] sync_q, sync_d;
    logic       rx_s, rx_prev;

    rx_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_err_q, par_err_d;

    logic       tick_full, tick_half;

    // Bits [1:0] form the synchroniser; bit 2 is the delayed copy for edge detect.
    assign sync_d  = {sync_q[1:0], rx};
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    assign tick_full = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign tick_half = (cnt_q == CW'(HALF - 1));

    // Synchroniser keeps running through clr; only rstn forces it to idle-high.
    always_ff @(posedge clk) begin
        if (!rstn) sync_q <= 3'b111;
        else       sync_q <= sync_d;
    end

    // State register and bit-timer flops.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    // Next-state logic: start-bit qualification, mid-bit sampling, framing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                cnt_d     = cnt_q + CW'(1);
                par_err_d = 1'b0;
                if (tick_half) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (tick_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef LOADER_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (tick_full) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (tick_full) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: byte/err decision is made on the stop-bit sample.
    always_comb begin
        rx_byte    = shift_q;
        byte_valid = 1'b0;
        err        = 1'b0;
        if (state_q == STOP && tick_full) begin
            if (rx_s && !par_err_q) byte_valid = 1'b1;
            else                    err        = 1'b1;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART loader: assembles received bytes little-endian into DATA_W-bit words
// and presents them with an incrementing word address on a valid/ready port.
// Keeps an XOR checksum, accepted-word count and sticky error flags.
// Optional macro LOADER_PARITY_EN selects 8E1 framing in uart_rx.
module uart_loader
    import fgba_loader_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 23,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              rx,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [7:0]        xorc,
    output logic [ADDR_W-1:0] word_cnt,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int     CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam int     NB      = DATA_W / BYTE_W;
    localparam int     IDXW    = $clog2(NB + 1);
    localparam longint TMO_CYC = longint'(TIMEOUT_BITS) * longint'(CPB);
    localparam int     TW      = $clog2(TMO_CYC + 1);

    logic [7:0]        rx_byte;
    logic              rx_valid, rx_err;

    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] asm_q, asm_d, asm_merged;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]        xorc_q, xorc_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    logic              complete, hs;
    logic [7:0]        word_xor;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .err       (rx_err)
    );

    // Assembly buffer with the incoming byte dropped into lane idx.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign asm_merged[gi*BYTE_W +: BYTE_W] =
            (idx_q == IDXW'(gi)) ? rx_byte : asm_q[gi*BYTE_W +: BYTE_W];
    end

    assign complete = rx_valid && (idx_q == IDXW'(NB - 1));
    assign hs       = wr_valid_q && wr_ready;

    // Byte-wise XOR of the presented word, folded into xorc on handshake.
    always_comb begin
        word_xor = '0;
        for (int i = 0; i < NB; i++) word_xor = word_xor ^ wr_data_q[i*BYTE_W +: BYTE_W];
    end

    // All state flops; clr behaves as reset for everything but the synchroniser.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            idx_q       <= '0;
            asm_q       <= '0;
            tmo_q       <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            word_cnt_q  <= '0;
            xorc_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            tmo_q       <= tmo_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            word_cnt_q  <= word_cnt_d;
            xorc_q      <= xorc_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Assembler index and idle timeout; a fresh byte always beats the timeout.
    always_comb begin
        asm_d = asm_q;
        idx_d = idx_q;
        tmo_d = tmo_q;
        if (rx_valid) begin
            asm_d = asm_merged;
            tmo_d = '0;
            idx_d = complete ? '0 : idx_q + IDXW'(1);
        end else if (idx_q != '0) begin
            if (tmo_q == TW'(TMO_CYC - 1)) begin
                idx_d = '0;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Output register, handshake bookkeeping and sticky flags.
    always_comb begin
        wr_data_d   = wr_data_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        word_cnt_d  = word_cnt_q;
        xorc_d      = xorc_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q | rx_err;
        if (hs) begin
            wr_addr_d  = wr_addr_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + ADDR_W'(1);
            xorc_d     = xorc_q ^ word_xor;
            wr_valid_d = 1'b0;
        end
        if (complete) begin
            if (!wr_valid_q || hs) begin
                wr_data_d  = asm_merged;
                wr_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign xorc      = xorc_q;
    assign word_cnt  = word_cnt_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (idx_q != '0) | wr_valid_q;

endmodule
